// File: rtl/pic_init_sequencer.sv
// pic_init_sequencer: 8259A command-word sequencer.
// Edge-detects the decoded write strobes from the bus buffer. It tracks the
// ICW1 -> ICW2 -> [ICW3] -> [ICW4] initialization sequence and holds the
// configuration and mask registers. It also issues one-cycle OCW2 and poll
// pulses.
// Optional feature macro: PIC_CASCADE_EN. When it is defined, the ICW3 step
// exists and cascade_cfg is a register. When it is undefined, the device is
// forced to single mode and cascade_cfg is tied to 0.
module pic_init_sequencer #(
  parameter int unsigned VEC_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          internal_data_bus,
  input  logic                ICW1,
  input  logic                ICW2_4,
  input  logic                OCW1,
  input  logic                OCW2,
  input  logic                OCW3,
  output logic                init_done,
  output logic                ltim,
  output logic                sngl,
  output logic                ic4,
  output logic [VEC_BITS-1:0] vector_base,
  output logic [7:0]          cascade_cfg,
  output logic                upm,
  output logic                aeoi,
  output logic                ms,
  output logic                buf_mode,
  output logic                sfnm,
  output logic [7:0]          imr,
  output logic                ocw2_valid,
  output logic [2:0]          ocw2_cmd,
  output logic [2:0]          ocw2_level,
  output logic                rotate_aeoi,
  output logic                smm,
  output logic                read_isr,
  output logic                poll_req
);

  typedef enum logic [2:0] {
    StUninit,
    StWaitIcw2,
    StWaitIcw3,
    StWaitIcw4,
    StReady
  } state_e;

  localparam logic [2:0] CmdRotAeoiSet = 3'b100;
  localparam logic [2:0] CmdRotAeoiClr = 3'b000;
  localparam logic [2:0] CmdNop        = 3'b010;

  state_e state_q, state_d;

  // Strobe bit order: {OCW3, OCW2, OCW1, ICW2_4, ICW1}
  logic [4:0] strobe_now;
  logic [4:0] strobe_q;
  logic [4:0] rise;

  logic icw1_edge, icw2_4_edge, ocw1_edge, ocw2_edge, ocw3_edge;
  logic sngl_eff;

  logic                ltim_q, ltim_d;
  logic                sngl_q, sngl_d;
  logic                ic4_q, ic4_d;
  logic [VEC_BITS-1:0] vector_base_q, vector_base_d;
  logic [4:0]          icw4_q, icw4_d;
  logic [7:0]          imr_q, imr_d;
  logic                ocw2_valid_q, ocw2_valid_d;
  logic [2:0]          ocw2_cmd_q, ocw2_cmd_d;
  logic [2:0]          ocw2_level_q, ocw2_level_d;
  logic                rotate_aeoi_q, rotate_aeoi_d;
  logic                smm_q, smm_d;
  logic                read_isr_q, read_isr_d;
  logic                poll_req_q, poll_req_d;
`ifdef PIC_CASCADE_EN
  logic [7:0]          cascade_q, cascade_d;
`endif

  assign strobe_now = {OCW3, OCW2, OCW1, ICW2_4, ICW1};
  assign rise       = strobe_now & ~strobe_q;

  // ICW1 pre-empts every other strobe edge in the same cycle
  assign icw1_edge   = rise[0];
  assign icw2_4_edge = rise[1] & ~icw1_edge;
  assign ocw1_edge   = rise[2] & ~icw1_edge & (state_q == StReady);
  assign ocw2_edge   = rise[3] & ~icw1_edge & (state_q == StReady);
  assign ocw3_edge   = rise[4] & ~icw1_edge & (state_q == StReady);

`ifdef PIC_CASCADE_EN
  assign sngl_eff = sngl_q;
`else
  // Without cascade support the ICW3 step never exists
  assign sngl_eff = 1'b1;
`endif

  // Next-state logic for the sequence FSM and every held register
  always_comb begin
    state_d       = state_q;
    ltim_d        = ltim_q;
    sngl_d        = sngl_q;
    ic4_d         = ic4_q;
    vector_base_d = vector_base_q;
    icw4_d        = icw4_q;
    imr_d         = imr_q;
    ocw2_valid_d  = 1'b0;
    ocw2_cmd_d    = ocw2_cmd_q;
    ocw2_level_d  = ocw2_level_q;
    rotate_aeoi_d = rotate_aeoi_q;
    smm_d         = smm_q;
    read_isr_d    = read_isr_q;
    poll_req_d    = 1'b0;
`ifdef PIC_CASCADE_EN
    cascade_d     = cascade_q;
`endif

    if (icw1_edge) begin
      ltim_d        = internal_data_bus[3];
      sngl_d        = internal_data_bus[1];
      ic4_d         = internal_data_bus[0];
      imr_d         = 8'h00;
      smm_d         = 1'b0;
      rotate_aeoi_d = 1'b0;
      read_isr_d    = 1'b0;
      icw4_d        = 5'b0;
      state_d       = StWaitIcw2;
    end else begin
      if (icw2_4_edge) begin
        unique case (state_q)
          StWaitIcw2: begin
            vector_base_d = internal_data_bus[7 -: VEC_BITS];
            if (!sngl_eff) begin
              state_d = StWaitIcw3;
            end else if (ic4_q) begin
              state_d = StWaitIcw4;
            end else begin
              state_d = StReady;
            end
          end
          StWaitIcw3: begin
`ifdef PIC_CASCADE_EN
            cascade_d = internal_data_bus;
`endif
            state_d = ic4_q ? StWaitIcw4 : StReady;
          end
          StWaitIcw4: begin
            icw4_d  = internal_data_bus[4:0];
            state_d = StReady;
          end
          default: ; // UNINIT and READY ignore ICW2_4
        endcase
      end

      if (ocw1_edge) begin
        imr_d = internal_data_bus;
      end

      if (ocw2_edge && (internal_data_bus[7:5] != CmdNop)) begin
        ocw2_valid_d = 1'b1;
        ocw2_cmd_d   = internal_data_bus[7:5];
        ocw2_level_d = internal_data_bus[2:0];
        if (internal_data_bus[7:5] == CmdRotAeoiSet) begin
          rotate_aeoi_d = 1'b1;
        end else if (internal_data_bus[7:5] == CmdRotAeoiClr) begin
          rotate_aeoi_d = 1'b0;
        end
      end

      if (ocw3_edge) begin
        if (internal_data_bus[6]) smm_d      = internal_data_bus[5];
        if (internal_data_bus[1]) read_isr_d = internal_data_bus[0];
        if (internal_data_bus[2]) poll_req_d = 1'b1;
      end
    end
  end

  // State, edge-history and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StUninit;
      strobe_q      <= 5'b0;
      ltim_q        <= 1'b0;
      sngl_q        <= 1'b0;
      ic4_q         <= 1'b0;
      vector_base_q <= '0;
      icw4_q        <= 5'b0;
      imr_q         <= 8'h00;
      ocw2_valid_q  <= 1'b0;
      ocw2_cmd_q    <= 3'b0;
      ocw2_level_q  <= 3'b0;
      rotate_aeoi_q <= 1'b0;
      smm_q         <= 1'b0;
      read_isr_q    <= 1'b0;
      poll_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      strobe_q      <= strobe_now;
      ltim_q        <= ltim_d;
      sngl_q        <= sngl_d;
      ic4_q         <= ic4_d;
      vector_base_q <= vector_base_d;
      icw4_q        <= icw4_d;
      imr_q         <= imr_d;
      ocw2_valid_q  <= ocw2_valid_d;
      ocw2_cmd_q    <= ocw2_cmd_d;
      ocw2_level_q  <= ocw2_level_d;
      rotate_aeoi_q <= rotate_aeoi_d;
      smm_q         <= smm_d;
      read_isr_q    <= read_isr_d;
      poll_req_q    <= poll_req_d;
    end
  end

`ifdef PIC_CASCADE_EN
  // ICW3 cascade configuration register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cascade_q <= 8'h00;
    end else begin
      cascade_q <= cascade_d;
    end
  end

  assign cascade_cfg = cascade_q;
`else
  assign cascade_cfg = 8'h00;
`endif

  assign init_done   = (state_q == StReady);
  assign ltim        = ltim_q;
  assign sngl        = sngl_q;
  assign ic4         = ic4_q;
  assign vector_base = vector_base_q;
  assign upm         = icw4_q[0];
  assign aeoi        = icw4_q[1];
  assign ms          = icw4_q[2];
  assign buf_mode    = icw4_q[3];
  assign sfnm        = icw4_q[4];
  assign imr         = imr_q;
  assign ocw2_valid  = ocw2_valid_q;
  assign ocw2_cmd    = ocw2_cmd_q;
  assign ocw2_level  = ocw2_level_q;
  assign rotate_aeoi = rotate_aeoi_q;
  assign smm         = smm_q;
  assign read_isr    = read_isr_q;
  assign poll_req    = poll_req_q;

endmodule

// File: tb/tb_pic_init_sequencer.sv
// Directed, table-driven bench for pic_init_sequencer (default or cascade build).
module tb_pic_init_sequencer;

  localparam logic [2:0] SelIcw1 = 3'd0;
  localparam logic [2:0] SelIcw24 = 3'd1;
  localparam logic [2:0] SelOcw1 = 3'd2;
  localparam logic [2:0] SelOcw2 = 3'd3;
  localparam logic [2:0] SelOcw3 = 3'd4;

`ifdef PIC_CASCADE_EN
  localparam logic       R16Done = 1'b0;
  localparam logic [4:0] R16Icw4 = 5'h00;
  localparam logic [7:0] R16Cas  = 8'h04;
  localparam logic [4:0] R17Icw4 = 5'h01;
`else
  localparam logic       R16Done = 1'b1;
  localparam logic [4:0] R16Icw4 = 5'h04;
  localparam logic [7:0] R16Cas  = 8'h00;
  localparam logic [4:0] R17Icw4 = 5'h04;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] internal_data_bus = 8'h00;
  logic       ICW1 = 1'b0, ICW2_4 = 1'b0, OCW1 = 1'b0, OCW2 = 1'b0, OCW3 = 1'b0;
  logic       init_done, ltim, sngl, ic4;
  logic [4:0] vector_base;
  logic [7:0] cascade_cfg;
  logic       upm, aeoi, ms, buf_mode, sfnm;
  logic [7:0] imr;
  logic       ocw2_valid;
  logic [2:0] ocw2_cmd, ocw2_level;
  logic       rotate_aeoi, smm, read_isr, poll_req;

  int n_checks = 0;
  int n_fail = 0;

  pic_init_sequencer #(.VEC_BITS(5)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .internal_data_bus (internal_data_bus),
    .ICW1              (ICW1),
    .ICW2_4            (ICW2_4),
    .OCW1              (OCW1),
    .OCW2              (OCW2),
    .OCW3              (OCW3),
    .init_done         (init_done),
    .ltim              (ltim),
    .sngl              (sngl),
    .ic4               (ic4),
    .vector_base       (vector_base),
    .cascade_cfg       (cascade_cfg),
    .upm               (upm),
    .aeoi              (aeoi),
    .ms                (ms),
    .buf_mode          (buf_mode),
    .sfnm              (sfnm),
    .imr               (imr),
    .ocw2_valid        (ocw2_valid),
    .ocw2_cmd          (ocw2_cmd),
    .ocw2_level        (ocw2_level),
    .rotate_aeoi       (rotate_aeoi),
    .smm               (smm),
    .read_isr          (read_isr),
    .poll_req          (poll_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic       done;
    logic [2:0] icw1;  // {ltim, sngl, ic4}
    logic [4:0] vb;
    logic [4:0] icw4;  // {sfnm, buf_mode, ms, aeoi, upm}
    logic [7:0] cas;
    logic [7:0] imr;
    logic       rot;
    logic       smm;
    logic       risr;
    logic       valid;
    logic [2:0] cmd;
    logic [2:0] lvl;
    logic       poll;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_strobe(input logic [2:0] sel, input logic val);
    case (sel)
      SelIcw1:  ICW1 = val;
      SelIcw24: ICW2_4 = val;
      SelOcw1:  OCW1 = val;
      SelOcw2:  OCW2 = val;
      default:  OCW3 = val;
    endcase
  endtask

  task automatic release_all();
    @(negedge clk);
    ICW1 = 1'b0; ICW2_4 = 1'b0; OCW1 = 1'b0; OCW2 = 1'b0; OCW3 = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] all_outputs();
    return {23'b0, init_done, ltim, sngl, ic4, vector_base, cascade_cfg, upm, aeoi, ms,
            buf_mode, sfnm, imr, ocw2_valid, ocw2_cmd, ocw2_level, rotate_aeoi, smm,
            read_isr, poll_req};
  endfunction

  initial begin
    int polls;
    // sel, data, done, icw1, vb, icw4, cas, imr, rot, smm, risr, valid, cmd, lvl, poll
    vecs.push_back('{SelOcw1,  8'hFF, 1'b0, 3'b000, 5'd0, 5'h00, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 0});
    vecs.push_back('{SelIcw1,  8'h13, 1'b0, 3'b011, 5'd0, 5'h00, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 0});
    vecs.push_back('{SelIcw24, 8'h20, 1'b0, 3'b011, 5'd4, 5'h00, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 0});
    vecs.push_back('{SelIcw24, 8'h03, 1'b1, 3'b011, 5'd4, 5'h03, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 3'd0, 0});
    vecs.push_back('{SelOcw1,  8'hA5, 1'b1, 3'b011, 5'd4, 5'h03, 8'h00, 8'hA5, 0, 0, 0, 0, 3'd0, 3'd0, 0});
    vecs.push_back('{SelOcw2,  8'h63, 1'b1, 3'b011, 5'd4, 5'h03, 8'h00, 8'hA5, 0, 0, 0, 1, 3'd3, 3'd3, 0});
    vecs.push_back('{SelOcw2,  8'h80, 1'b1, 3'b011, 5'd4, 5'h03, 8'h00, 8'hA5, 1, 0, 0, 1, 3'd4, 3'd0, 0});
    vecs.push_back('{SelOcw2,  8'h40, 1'b1, 3'b011, 5'd4, 5'h03, 8'h00, 8'hA5, 1, 0, 0, 0, 3'd4, 3'd0, 0});
    vecs.push_back('{SelOcw3,  8'h6B, 1'b1, 3'b011, 5'd4, 5'h03, 8'h00, 8'hA5, 1, 1, 1, 0, 3'd4, 3'd0, 0});
    vecs.push_back('{SelOcw3,  8'h0C, 1'b1, 3'b011, 5'd4, 5'h03, 8'h00, 8'hA5, 1, 1, 1, 0, 3'd4, 3'd0, 1});
    vecs.push_back('{SelIcw24, 8'h55, 1'b1, 3'b011, 5'd4, 5'h03, 8'h00, 8'hA5, 1, 1, 1, 0, 3'd4, 3'd0, 0});
    vecs.push_back('{SelIcw1,  8'h1B, 1'b0, 3'b111, 5'd4, 5'h00, 8'h00, 8'h00, 0, 0, 0, 0, 3'd4, 3'd0, 0});
    vecs.push_back('{SelOcw1,  8'h33, 1'b0, 3'b111, 5'd4, 5'h00, 8'h00, 8'h00, 0, 0, 0, 0, 3'd4, 3'd0, 0});
    vecs.push_back('{SelIcw1,  8'h11, 1'b0, 3'b001, 5'd4, 5'h00, 8'h00, 8'h00, 0, 0, 0, 0, 3'd4, 3'd0, 0});
    vecs.push_back('{SelIcw24, 8'h08, 1'b0, 3'b001, 5'd1, 5'h00, 8'h00, 8'h00, 0, 0, 0, 0, 3'd4, 3'd0, 0});
    vecs.push_back('{SelIcw24, 8'h04, R16Done, 3'b001, 5'd1, R16Icw4, R16Cas, 8'h00, 0, 0, 0, 0, 3'd4, 3'd0, 0});
    vecs.push_back('{SelIcw24, 8'h01, 1'b1, 3'b001, 5'd1, R17Icw4, R16Cas, 8'h00, 0, 0, 0, 0, 3'd4, 3'd0, 0});

    // Reset state
    repeat (2) @(posedge clk);
    #1 check("reset_outputs", all_outputs(), 64'h0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      internal_data_bus = vecs[i].data;
      set_strobe(vecs[i].sel, 1'b1);
      @(posedge clk); #1;
      check($sformatf("v%0d_init_done", i), 64'(init_done), 64'(vecs[i].done));
      check($sformatf("v%0d_icw1", i), 64'({ltim, sngl, ic4}), 64'(vecs[i].icw1));
      check($sformatf("v%0d_vector_base", i), 64'(vector_base), 64'(vecs[i].vb));
      check($sformatf("v%0d_icw4", i), 64'({sfnm, buf_mode, ms, aeoi, upm}), 64'(vecs[i].icw4));
      check($sformatf("v%0d_cascade_cfg", i), 64'(cascade_cfg), 64'(vecs[i].cas));
      check($sformatf("v%0d_imr", i), 64'(imr), 64'(vecs[i].imr));
      check($sformatf("v%0d_ocw3_modes", i), 64'({rotate_aeoi, smm, read_isr}),
            64'({vecs[i].rot, vecs[i].smm, vecs[i].risr}));
      check($sformatf("v%0d_ocw2_valid", i), 64'(ocw2_valid), 64'(vecs[i].valid));
      check($sformatf("v%0d_ocw2_cmd_lvl", i), 64'({ocw2_cmd, ocw2_level}),
            64'({vecs[i].cmd, vecs[i].lvl}));
      check($sformatf("v%0d_poll_req", i), 64'(poll_req), 64'(vecs[i].poll));
      release_all();
      check($sformatf("v%0d_pulses_end", i), 64'({ocw2_valid, poll_req}), 64'h0);
    end

    // OCW1 held for five cycles with changing data: only the first byte loads
    @(negedge clk);
    internal_data_bus = 8'h5A;
    OCW1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      internal_data_bus = 8'h11 * 8'(k + 1);
    end
    release_all();
    check("held_ocw1_imr", 64'(imr), 64'h5A);

    // Poll held for three cycles: exactly one poll_req pulse
    polls = 0;
    @(negedge clk);
    internal_data_bus = 8'h04;
    OCW3 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (poll_req) polls++;
      if (k < 2) @(negedge clk);
    end
    release_all();
    if (poll_req) polls++;
    check("held_poll_count", 64'(polls), 64'd1);

    // ICW1 and OCW1 together: ICW1 wins, OCW1 discarded
    @(negedge clk);
    internal_data_bus = 8'h11;
    ICW1 = 1'b1;
    OCW1 = 1'b1;
    @(posedge clk); #1;
    check("simul_imr", 64'(imr), 64'h00);
    check("simul_init_done", 64'(init_done), 64'h0);
    check("simul_icw1", 64'({ltim, sngl, ic4}), 64'b001);
    release_all();

    // Advance to the ICW3 (cascade) or ICW4 wait, then reset asynchronously
    @(negedge clk);
    internal_data_bus = 8'h08;
    ICW2_4 = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_vb", 64'(vector_base), 64'h01);
    release_all();
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", all_outputs(), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_init_done", 64'(init_done), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
